// File: rtl/latch_seq_pkg.sv
// Shared types and helpers for the latch write sequencer.
package latch_seq_pkg;

    // Sequencer phases: one request walks IDLE -> SETUP -> STROBE -> HOLD -> DONE.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } seq_state_e;

    // clog2 of the latch count, never below 1 so a bus width derived from it is legal.
    function automatic int clog2_n(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Largest of three phase lengths; sizes the shared cycle counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/seq_cycle_timer.sv
// Loadable down-counter with a terminal-count flag; times every phase of the sequencer.
module seq_cycle_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Load wins; otherwise count down and park at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Terminal count: the current cycle is the last one of the phase.
    assign tc = (count_q == '0);

endmodule

// File: rtl/latch_write_sequencer.sv
// Drives a bank of external latches: presents data, strobes one enable (or all
// enables for a clear), holds, then reports completion. All outputs registered.
module latch_write_sequencer
    import latch_seq_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int N_LATCH    = 4,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    // One extra address bit so that out-of-range indices can be expressed and flagged.
    input  logic [clog2_n(N_LATCH):0]   s_addr,
    input  logic [DATA_W-1:0]           s_data,
    input  logic                        s_clr,
    output logic [DATA_W-1:0]           lat_d,
    output logic [N_LATCH-1:0]          lat_en,
    output logic                        lat_rst,
    output logic                        done,
    output logic                        err
);

    localparam int ADDR_W = clog2_n(N_LATCH) + 1;
    localparam int CNT_W  = $clog2(max3(SETUP_CYC, STROBE_CYC, HOLD_CYC) + 1);

    // Timer load values are length-1: the phase ends on the cycle the count reaches zero.
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'((SETUP_CYC  > 0) ? SETUP_CYC  - 1 : 0);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'((STROBE_CYC > 0) ? STROBE_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'((HOLD_CYC   > 0) ? HOLD_CYC   - 1 : 0);

    seq_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                clr_q, clr_d;
    logic [DATA_W-1:0]   lat_d_q, lat_d_d;
    logic                lat_rst_q, lat_rst_d;
    logic [N_LATCH-1:0]  lat_en_q, lat_en_d;
    logic                s_ready_q, s_ready_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                tmr_load;
    logic [CNT_W-1:0]    tmr_val;
    logic                tmr_tc;

    logic [N_LATCH-1:0]  strobe_mask;
    logic                addr_bad;

    seq_cycle_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    // Enable pattern for the request being set up: every latch on a clear, else the
    // addressed one. An out-of-range index matches no bit and leaves the bank untouched.
    generate
        for (genvar gi = 0; gi < N_LATCH; gi++) begin : g_mask
            assign strobe_mask[gi] = clr_d | (addr_d == ADDR_W'(gi));
        end
    endgenerate

    assign addr_bad = (addr_d >= ADDR_W'(N_LATCH));

    // Next-state logic: accept in IDLE, then walk the timed phases.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        clr_d     = clr_q;
        lat_d_d   = lat_d_q;
        lat_rst_d = lat_rst_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        case (state_q)
            IDLE: begin
                if (s_valid && s_ready_q) begin
                    addr_d    = s_addr;
                    clr_d     = s_clr;
                    lat_d_d   = s_clr ? '0 : s_data;
                    lat_rst_d = s_clr;
                    tmr_load  = 1'b1;
                    if (SETUP_CYC > 0) begin
                        state_d = SETUP;
                        tmr_val = SETUP_LD;
                    end else begin
                        state_d = STROBE;
                        tmr_val = STROBE_LD;
                    end
                end
            end
            SETUP: begin
                if (tmr_tc) begin
                    state_d  = STROBE;
                    tmr_load = 1'b1;
                    tmr_val  = STROBE_LD;
                end
            end
            STROBE: begin
                if (tmr_tc) begin
                    if (HOLD_CYC > 0) begin
                        state_d  = HOLD;
                        tmr_load = 1'b1;
                        tmr_val  = HOLD_LD;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            HOLD: begin
                if (tmr_tc) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d   = IDLE;
                lat_rst_d = 1'b0;
            end
            default: begin
                state_d   = IDLE;
                lat_rst_d = 1'b0;
            end
        endcase
    end

    // Output values are derived from the state being entered so they can be registered.
    always_comb begin
        s_ready_d = (state_d == IDLE);
        lat_en_d  = (state_d == STROBE) ? strobe_mask : '0;
        done_d    = (state_d == DONE);
        err_d     = (state_d == DONE) && !clr_d && addr_bad;
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            clr_q     <= 1'b0;
            lat_d_q   <= '0;
            lat_rst_q <= 1'b0;
            lat_en_q  <= '0;
            s_ready_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            clr_q     <= clr_d;
            lat_d_q   <= lat_d_d;
            lat_rst_q <= lat_rst_d;
            lat_en_q  <= lat_en_d;
            s_ready_q <= s_ready_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign s_ready = s_ready_q;
    assign lat_d   = lat_d_q;
    assign lat_en  = lat_en_q;
    assign lat_rst = lat_rst_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule
